mem_line_arbiter: RTL and testbench

//  Shares the single 128-bit line RAM between the I-cache refill port and the D-cache refill/writeback port.

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_rr_arbiter.sv | 24 ++
 rtl/mem_line_arbiter.sv | 112 +++++++++++
 tb/tb_mem_line_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the line-RAM arbiter: FSM states, RAM access type
// and requester (owner) encoding.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam logic [1:0] MTYPE_LINE = 2'b11;
  localparam int         LINE_BYTES = 16;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-way round-robin grant between the I-cache and D-cache refill ports.
// ptr=0 favours the D-cache on a tie, ptr=1 favours the I-cache.
module mem_rr_arbiter
  import mem_pkg::*;
(
  input  logic       ptr,
  input  logic       i_valid,
  input  logic       d_valid,
  input  logic       en,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (en) begin
      if (d_valid && (!i_valid || !ptr)) begin
        grant[OWN_D] = 1'b1;
      end else if (i_valid) begin
        grant[OWN_I] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_line_arbiter.sv
// Shares one 128-bit line RAM between the I-cache and D-cache refill ports, one
// line transaction at a time, with a programmable latency modelling main memory.
module mem_line_arbiter
  import mem_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_resp_valid,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_wen,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [LINE_W-1:0] d_req_wdata,
  output logic              d_resp_valid,
  output logic [LINE_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [LINE_W-1:0] ram_din,
  output logic              ram_we,
  output logic [1:0]        ram_mtype,
  input  logic [LINE_W-1:0] ram_dout,
  output logic              busy
);

  localparam int                CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_BYTES - 1);

  state_t            state;
  state_t            state_nxt;
  logic              ptr;
  logic [CNT_W-1:0]  cnt;
  logic              owner;
  logic              wen_q;
  logic [LINE_W-1:0] wdata_q;
  logic [1:0]        grant;
  logic              accept;
  logic              last_busy;

  // Grants are suppressed while reset is held so both ready outputs read 0.
  mem_rr_arbiter u_arb (
    .ptr     (ptr),
    .i_valid (i_req_valid),
    .d_valid (d_req_valid),
    .en      ((state == IDLE) && !rst),
    .grant   (grant)
  );

  assign i_req_ready = grant[OWN_I];
  assign d_req_ready = grant[OWN_D];
  assign accept      = |grant;
  assign last_busy   = (state == BUSY) && (cnt == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      cnt        <= '0;
      owner      <= OWN_I;
      wen_q      <= 1'b0;
      ram_addr   <= '0;
      resp_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        ram_addr <= (grant[OWN_D] ? d_req_addr : i_req_addr) & ~LINE_MASK;
        owner    <= grant[OWN_D] ? OWN_D : OWN_I;
        wen_q    <= grant[OWN_D] & d_req_wen;
        cnt      <= CNT_W'(LATENCY - 1);
      end
      if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (last_busy && !wen_q) begin
        resp_rdata <= ram_dout;
      end
      // Hand the next tie to whoever did not own this transaction.
      if (state == RESP) begin
        ptr <= (owner == OWN_D);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && grant[OWN_D]) begin
      wdata_q <= d_req_wdata;
    end
  end

  assign ram_we       = last_busy && wen_q;
  assign ram_din      = ram_we ? wdata_q : '0;
  assign ram_mtype    = MTYPE_LINE;
  assign busy         = (state != IDLE);
  assign i_resp_valid = (state == RESP) && (owner == OWN_I);
  assign d_resp_valid = (state == RESP) && (owner == OWN_D);

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Bench for mem_line_arbiter: table-driven and randomized transactions against a
// transaction-level model, a mid-write reset and a LATENCY=1 back-to-back check.
module tb_mem_line_arbiter;

  localparam int L = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         preload;
  logic         i_req_valid, i_req_ready, i_resp_valid;
  logic [31:0]  i_req_addr;
  logic         d_req_valid, d_req_ready, d_req_wen, d_resp_valid;
  logic [31:0]  d_req_addr;
  logic [127:0] d_req_wdata, resp_rdata, ram_din, ram_dout;
  logic [31:0]  ram_addr;
  logic         ram_we, busy;
  logic [1:0]   ram_mtype;

  logic         l1_iv, l1_ir, l1_irv, l1_dr, l1_drv, l1_we, l1_busy;
  logic [31:0]  l1_ia, l1_addr;
  logic [127:0] l1_rdata, l1_din, l1_dout;
  logic [1:0]   l1_mt;
  logic         l1_dv = 1'b0;
  logic         l1_dw = 1'b0;
  logic [31:0]  l1_da = '0;
  logic [127:0] l1_dd = '0;

  logic [127:0] ram     [64];
  logic [127:0] ref_mem [64];
  int we_cnt = 0;
  int resp_cnt = 0;
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_line_arbiter #(.LATENCY(L), .ADDR_W(32), .LINE_W(128)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_wen(d_req_wen),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_resp_valid(d_resp_valid),
    .resp_rdata(resp_rdata), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_mtype(ram_mtype), .ram_dout(ram_dout), .busy(busy)
  );

  mem_line_arbiter #(.LATENCY(1), .ADDR_W(32), .LINE_W(128)) dut1 (
    .clk(clk), .rst(rst),
    .i_req_valid(l1_iv), .i_req_ready(l1_ir), .i_req_addr(l1_ia),
    .i_resp_valid(l1_irv),
    .d_req_valid(l1_dv), .d_req_ready(l1_dr), .d_req_wen(l1_dw),
    .d_req_addr(l1_da), .d_req_wdata(l1_dd), .d_resp_valid(l1_drv),
    .resp_rdata(l1_rdata), .ram_addr(l1_addr), .ram_din(l1_din), .ram_we(l1_we),
    .ram_mtype(l1_mt), .ram_dout(l1_dout), .busy(l1_busy)
  );

  function automatic logic [127:0] pat(input int i);
    return {4{32'hC0DE_0000 + 32'(i)}};
  endfunction

  // Line RAM model: combinational read, synchronous write, 64-line window.
  assign ram_dout = ram[ram_addr[9:4]];
  assign l1_dout  = {4{l1_addr}};

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) ram[i] <= pat(i);
    end else if (ram_we) begin
      ram[ram_addr[9:4]] <= ram_din;
      we_cnt <= we_cnt + 1;
    end
    if (i_resp_valid || d_resp_valid) resp_cnt <= resp_cnt + 1;
  end

  task automatic chk_b(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_v(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model state
  bit           prefer_d;
  bit           pend_i, pend_d, pd_wen;
  logic [31:0]  pi_addr, pd_addr;
  logic [127:0] pd_data, last_rdata;

  // One arbitration round, starting and ending on the falling edge of an IDLE cycle.
  task automatic round(input bit new_i, input logic [31:0] ai, input bit new_d,
                       input logic [31:0] ad, input bit wd, input logic [127:0] dd,
                       input bit use_tbl, input bit tbl_d, input logic [31:0] tbl_addr);
    bit           exp_d, wen;
    logic [31:0]  masked, exp_a;
    logic [127:0] wdat;
    int           idx;
    if (new_i) begin pend_i = 1; pi_addr = ai; end
    if (new_d) begin pend_d = 1; pd_addr = ad; pd_wen = wd; pd_data = dd; end
    i_req_valid = pend_i; i_req_addr = pi_addr;
    d_req_valid = pend_d; d_req_addr = pd_addr; d_req_wen = pd_wen; d_req_wdata = pd_data;
    exp_d  = use_tbl ? tbl_d : (pend_d && (!pend_i || prefer_d));
    masked = (exp_d ? pd_addr : pi_addr) & 32'hFFFF_FFF0;
    exp_a  = use_tbl ? tbl_addr : masked;
    wen    = exp_d && pd_wen;
    wdat   = pd_data;
    idx    = int'(masked[9:4]);
    #1;
    chk_b("idle_busy", busy, 1'b0);
    chk_b("i_ready", i_req_ready, !exp_d);
    chk_b("d_ready", d_req_ready, exp_d);
    if (wen) ref_mem[idx] = wdat;
    else last_rdata = ref_mem[idx];
    prefer_d = !exp_d;
    if (exp_d) pend_d = 0; else pend_i = 0;
    @(posedge clk);
    for (int k = 1; k <= L; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (exp_d) begin d_req_valid = 0; d_req_addr = $urandom; d_req_wdata = {4{$urandom}}; end
        else begin i_req_valid = 0; i_req_addr = $urandom; end
      end
      #1;
      chk_b("busy", busy, 1'b1);
      chk_v("ram_addr", 128'(ram_addr), 128'(exp_a));
      chk_b("ram_we", ram_we, wen && (k == L));
      if (wen && k == L) chk_v("ram_din", ram_din, wdat);
      chk_b("i_ready_busy", i_req_ready, 1'b0);
      chk_b("d_ready_busy", d_req_ready, 1'b0);
      chk_b("resp_early", i_resp_valid | d_resp_valid, 1'b0);
      chk_v("mtype", 128'(ram_mtype), 128'(2'b11));
    end
    @(negedge clk);
    #1;
    chk_b("i_resp", i_resp_valid, !exp_d);
    chk_b("d_resp", d_resp_valid, exp_d);
    chk_v("rdata", resp_rdata, last_rdata);
    chk_b("resp_we", ram_we, 1'b0);
    @(negedge clk);
  endtask

  typedef struct {
    bit           new_i;
    logic [31:0]  ai;
    bit           new_d;
    logic [31:0]  ad;
    bit           wd;
    logic [127:0] dd;
    bit           exp_d;
    logic [31:0]  exp_addr;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int          we0, rs0, na, nr;
    int          acc [4];
    int          rsp [4];
    logic [31:0] base;
    bit          upd;
    tbl[0] = '{1, 32'h0000_0040, 0, 32'h0, 0, '0, 0, 32'h0000_0040};
    tbl[1] = '{0, 32'h0, 1, 32'h0000_0013, 1, {16{8'hA5}}, 1, 32'h0000_0010};
    tbl[2] = '{1, 32'h0000_001F, 0, 32'h0, 0, '0, 0, 32'h0000_0010};
    tbl[3] = '{1, 32'h0000_0020, 1, 32'h0000_0035, 0, '0, 1, 32'h0000_0030};
    tbl[4] = '{0, 32'h0, 0, 32'h0, 0, '0, 0, 32'h0000_0020};
    tbl[5] = '{1, 32'h0000_0050, 1, 32'h0000_0064, 1, {4{32'h1357_9BDF}}, 1, 32'h0000_0060};
    tbl[6] = '{0, 32'h0, 0, 32'h0, 0, '0, 0, 32'h0000_0050};
    tbl[7] = '{1, 32'h0000_0060, 1, 32'h1234_5677, 0, '0, 1, 32'h1234_5670};
    tbl[8] = '{0, 32'h0, 0, 32'h0, 0, '0, 0, 32'h0000_0060};
    for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);
    prefer_d = 1; pend_i = 0; pend_d = 0; pd_wen = 0;
    pi_addr = '0; pd_addr = '0; pd_data = '0; last_rdata = '0;
    l1_iv = 0; l1_ia = '0;

    // Reset with both requests asserted
    rst = 1; preload = 1;
    i_req_valid = 1; i_req_addr = 32'h40; d_req_valid = 1; d_req_wen = 1;
    d_req_addr = 32'h13; d_req_wdata = '1;
    @(negedge clk); @(negedge clk); #1;
    chk_b("rst_i_ready", i_req_ready, 1'b0);
    chk_b("rst_d_ready", d_req_ready, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_ram_we", ram_we, 1'b0);
    chk_v("rst_ram_addr", 128'(ram_addr), '0);
    chk_v("rst_ram_din", ram_din, '0);
    chk_v("rst_rdata", resp_rdata, '0);
    chk_b("rst_resp", i_resp_valid | d_resp_valid, 1'b0);
    rst = 0; preload = 0; i_req_valid = 0; d_req_valid = 0;
    @(negedge clk);

    for (int v = 0; v < 9; v++)
      round(tbl[v].new_i, tbl[v].ai, tbl[v].new_d, tbl[v].ad, tbl[v].wd, tbl[v].dd,
            1, tbl[v].exp_d, tbl[v].exp_addr);

    // Reset during the second BUSY cycle of a write
    we0 = we_cnt; rs0 = resp_cnt;
    d_req_valid = 1; d_req_wen = 1; d_req_addr = 32'h0000_0088; d_req_wdata = {16{8'h5A}};
    #1; chk_b("rw_accept", d_req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk); d_req_valid = 0;
    @(negedge clk); rst = 1; i_req_valid = 1; i_req_addr = 32'h0;
    #1;
    chk_b("rw_busy", busy, 1'b0);
    chk_b("rw_we", ram_we, 1'b0);
    chk_v("rw_addr", 128'(ram_addr), '0);
    chk_v("rw_din", ram_din, '0);
    chk_v("rw_rdata", resp_rdata, '0);
    chk_b("rw_i_ready", i_req_ready, 1'b0);
    @(negedge clk); rst = 0; i_req_valid = 0;
    repeat (L + 3) @(negedge clk);
    chk_v("rw_we_count", 128'(we_cnt), 128'(we0));
    chk_v("rw_resp_count", 128'(resp_cnt), 128'(rs0));
    chk_v("rw_mem", ram[8], ref_mem[8]);
    prefer_d = 1; last_rdata = '0;

    // Randomized rounds
    for (int r = 0; r < 40; r++) begin
      bit ni, nd;
      ni = !pend_i && ($urandom_range(0, 1) == 1);
      nd = !pend_d && ($urandom_range(0, 1) == 1);
      if (!pend_i && !pend_d && !ni && !nd) ni = 1;
      round(ni, $urandom, nd, $urandom, ($urandom_range(0, 1) == 1), {4{$urandom}}, 0, 0, '0);
    end
    chk_v("rand_mem", ram[int'(pd_addr[9:4])], ref_mem[int'(pd_addr[9:4])]);

    // LATENCY=1: back-to-back reads on one port
    na = 0; nr = 0; upd = 0; base = 32'h0000_0105;
    l1_iv = 1; l1_ia = base;
    for (int c = 0; c < 12; c++) begin
      if (upd) begin l1_ia = l1_ia + 32'h10; upd = 0; end
      #1;
      if (l1_irv) begin
        if (nr < 4) begin
          rsp[nr] = c;
          chk_v("l1_rdata", l1_rdata, {4{32'h0000_0100 + 32'(nr) * 32'h10}});
        end
        nr++;
      end
      if (l1_iv && l1_ir) begin
        if (na < 4) acc[na] = c;
        na++; upd = 1;
      end
      @(negedge clk);
    end
    l1_iv = 0;
    chk_v("l1_accepts", 128'(na), 128'(4));
    chk_v("l1_resps", 128'(nr), 128'(4));
    if (na == 4 && nr == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk_v("l1_latency", 128'(rsp[k] - acc[k]), 128'(2));
        if (k > 0) chk_v("l1_spacing", 128'(acc[k] - acc[k-1]), 128'(3));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
